// File: rtl/lcd_text_buffer.sv
// Character-cell frame store: host writes glyph codes at a cursor, scan side yields font ROM addresses.
// Optional macro SCROLL_EN: newline on the last row scrolls the screen instead of wrapping to the top.
module lcd_text_buffer #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  input  logic [6:0]  scan_col,
  input  logic [4:0]  scan_row,
  input  logic [3:0]  scan_line,
  output logic [11:0] font_addr,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);

  typedef enum logic [1:0] {StClear, StIdle, StScrl} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   sweep_q, sweep_d;
  logic [6:0]      col_q, col_d;
  logic [4:0]      row_q, row_d;
  logic [4:0]      top_q;
  logic            newline;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;
  logic [7:0]      mem [CELLS];
  logic            scan_oob;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      char_q;
  logic [3:0]      line_q;

  function automatic logic [4:0] row_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

`ifdef SCROLL_EN
  logic [4:0] top_d;
  logic [4:0] clr_row;
  // Physical row that just left the top of the screen becomes the new, blank bottom line
  assign clr_row = (top_q == 5'd0) ? 5'(ROWS - 1) : top_q - 5'd1;
`else
  assign top_q = '0;
`endif

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    col_d   = col_q;
    row_d   = row_q;
    we      = 1'b0;
    waddr   = sweep_q;
    wdata   = BLANK_CHAR;
    newline = 1'b0;
`ifdef SCROLL_EN
    top_d   = top_q;
`endif
    unique case (state_q)
      StClear: begin
        we = 1'b1;
        if (sweep_q == AW'(CELLS - 1)) begin
          sweep_d = '0;
          col_d   = '0;
          row_d   = '0;
`ifdef SCROLL_EN
          top_d   = '0;
`endif
          state_d = StIdle;
        end else begin
          sweep_d = sweep_q + AW'(1);
        end
      end
      StIdle: begin
        if (wr_valid) begin
          if (wr_data == 8'h0C) begin
            state_d = StClear;
            sweep_d = '0;
          end else if (wr_data == 8'h0A) begin
            col_d   = '0;
            newline = 1'b1;
          end else begin
            we    = 1'b1;
            waddr = cell_addr(row_add(row_q, top_q), col_q);
            wdata = wr_data;
            if (col_q == 7'(COLS - 1)) begin
              col_d   = '0;
              newline = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
          if (newline) begin
            if (row_q != 5'(ROWS - 1)) begin
              row_d = row_q + 5'd1;
            end else begin
`ifdef SCROLL_EN
              top_d   = row_add(top_q, 5'd1);
              sweep_d = '0;
              state_d = StScrl;
`else
              row_d = '0;
`endif
            end
          end
        end
      end
`ifdef SCROLL_EN
      StScrl: begin
        we    = 1'b1;
        waddr = cell_addr(clr_row, sweep_q[6:0]);
        if (sweep_q == AW'(COLS - 1)) begin
          sweep_d = '0;
          state_d = StIdle;
        end else begin
          sweep_d = sweep_q + AW'(1);
        end
      end
`endif
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      sweep_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

`ifdef SCROLL_EN
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) top_q <= '0;
    else        top_q <= top_d;
  end
`endif

  always_ff @(posedge pixel_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign scan_oob = (32'(scan_col) >= COLS) || (32'(scan_row) >= ROWS);
  assign rd_addr  = scan_oob ? '0 : cell_addr(row_add(scan_row, top_q), scan_col);

  // Non-blocking read against the write above gives read-first behaviour on a collision
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      char_q <= '0;
      line_q <= '0;
    end else begin
      char_q <= scan_oob ? BLANK_CHAR : mem[rd_addr];
      line_q <= scan_line;
    end
  end

  assign font_addr  = {char_q, line_q};
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign wr_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer: scan results checked through an expected-value queue
// against a bench-side model of the logical screen contents.
module tb_lcd_text_buffer;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic [6:0]  scan_col;
  logic [4:0]  scan_row;
  logic [3:0]  scan_line;
  logic [11:0] font_addr;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  model [30][80];

  lcd_text_buffer dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .scan_col  (scan_col),
    .scan_row  (scan_row),
    .scan_line (scan_line),
    .font_addr (font_addr),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] code(input int r, input int c);
    return 8'(8'h21 + ((r * 7 + c) % 90));
  endfunction

  task automatic model_blank();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) model[r][c] = 8'h20;
  endtask

  task automatic wr(input logic [7:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge pixel_clk);
    while (wr_ready !== 1'b1 && n < 5000) begin
      n++;
      @(negedge pixel_clk);
    end
    if (n >= 5000) check("wr_ready_timeout", 32'(wr_ready), 32'd1);
    @(posedge pixel_clk);
    #1;
    wr_valid = 1'b0;
  endtask

  // Counts busy cycles (sampled at negedge) and cycles where wr_ready was wrongly high
  task automatic count_busy(output int n, output int rdy_hi);
    n = 0;
    rdy_hi = 0;
    @(negedge pixel_clk);
    while (busy === 1'b1 && n < 5000) begin
      if (wr_ready !== 1'b0) rdy_hi++;
      n++;
      @(negedge pixel_clk);
    end
  endtask

  task automatic scan_put(input int c, input int r, input int l, input logic [7:0] ch);
    @(posedge pixel_clk);
    #1;
    if (exp_q.size() > 0) check("font_addr", 32'(font_addr), 32'(exp_q.pop_front()));
    scan_col  = 7'(c);
    scan_row  = 5'(r);
    scan_line = 4'(l);
    exp_q.push_back({ch, 4'(l)});
  endtask

  task automatic scan_flush();
    @(posedge pixel_clk);
    #1;
    while (exp_q.size() > 0) check("font_addr", 32'(font_addr), 32'(exp_q.pop_front()));
  endtask

  task automatic scan_rows(input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < 80; c++) scan_put(c, r, (r + c) % 16, model[r][c]);
    scan_flush();
  endtask

  initial begin
    int n;
    int rdy_hi;
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    scan_col  = '0;
    scan_row  = '0;
    scan_line = '0;
    repeat (3) @(posedge pixel_clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_font_addr", 32'(font_addr), 32'h0);
    check("rst_cursor_col", 32'(cursor_col), 32'd0);
    check("rst_cursor_row", 32'(cursor_row), 32'd0);

    // Power-up clear
    rst_n = 1'b1;
    count_busy(n, rdy_hi);
    check("init_clear_cycles", 32'(n), 32'd2400);
    check("init_clear_ready_low", 32'(rdy_hi), 32'd0);
    model_blank();
    scan_rows(0, 29);

    // Single glyph and one-cycle scan latency
    wr(8'h41);
    model[0][0] = 8'h41;
    check("glyph_cursor_col", 32'(cursor_col), 32'd1);
    check("glyph_cursor_row", 32'(cursor_row), 32'd0);
    scan_put(0, 0, 5, 8'h41);
    scan_flush();
    scan_put(0, 0, 5, 8'h41);
    scan_put(1, 0, 9, 8'h20);
    scan_flush();

    // Out-of-range scan cells read as blank
    scan_put(80, 0, 3, 8'h20);
    scan_put(127, 5, 7, 8'h20);
    scan_put(10, 30, 1, 8'h20);
    scan_put(0, 31, 15, 8'h20);
    scan_flush();

    // Clear from a non-home cursor
    wr(8'h0C);
    count_busy(n, rdy_hi);
    check("clear_cycles", 32'(n), 32'd2400);
    check("clear_cursor_col", 32'(cursor_col), 32'd0);
    check("clear_cursor_row", 32'(cursor_row), 32'd0);
    model_blank();
    scan_rows(0, 0);

    // Full row of glyphs wraps to the next row
    for (int c = 0; c < 80; c++) begin
      wr(code(0, c));
      model[0][c] = code(0, c);
    end
    check("row_wrap_col", 32'(cursor_col), 32'd0);
    check("row_wrap_row", 32'(cursor_row), 32'd1);
    scan_rows(0, 1);
    wr(8'h0A);
    check("newline_col", 32'(cursor_col), 32'd0);
    check("newline_row", 32'(cursor_row), 32'd2);
    check("newline_not_busy", 32'(busy), 32'd0);

    // Clear mid-screen
    for (int c = 0; c < 3; c++) wr(code(2, c));
    check("mid_cursor_col", 32'(cursor_col), 32'd3);
    wr(8'h0C);
    count_busy(n, rdy_hi);
    check("mid_clear_cycles", 32'(n), 32'd2400);
    check("mid_clear_ready_low", 32'(rdy_hi), 32'd0);
    check("mid_clear_col", 32'(cursor_col), 32'd0);
    check("mid_clear_row", 32'(cursor_row), 32'd0);
    model_blank();
    scan_rows(0, 29);

    // Fill rows 0..28, a few glyphs on row 29, then newline on the last row
    for (int r = 0; r < 29; r++)
      for (int c = 0; c < 80; c++) begin
        wr(code(r, c));
        model[r][c] = code(r, c);
      end
    for (int c = 0; c < 5; c++) begin
      wr(code(29, c));
      model[29][c] = code(29, c);
    end
    check("fill_cursor_col", 32'(cursor_col), 32'd5);
    check("fill_cursor_row", 32'(cursor_row), 32'd29);
    wr(8'h0A);
`ifdef SCROLL_EN
    count_busy(n, rdy_hi);
    check("scroll_cycles", 32'(n), 32'd80);
    check("scroll_cursor_col", 32'(cursor_col), 32'd0);
    check("scroll_cursor_row", 32'(cursor_row), 32'd29);
    for (int r = 0; r < 29; r++)
      for (int c = 0; c < 80; c++) model[r][c] = model[r+1][c];
    for (int c = 0; c < 80; c++) model[29][c] = 8'h20;
    scan_rows(0, 29);
`else
    check("wrap_cursor_col", 32'(cursor_col), 32'd0);
    check("wrap_cursor_row", 32'(cursor_row), 32'd0);
    @(negedge pixel_clk);
    check("wrap_not_busy", 32'(busy), 32'd0);
    check("wrap_ready", 32'(wr_ready), 32'd1);
    scan_rows(0, 1);
    scan_rows(28, 29);
`endif

    // Reset in the middle of a clear sweep
    wr(8'h0C);
    repeat (1000) @(posedge pixel_clk);
    #1;
    for (int c = 0; c < 0; c++) wr(8'h00);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_ready", 32'(wr_ready), 32'd0);
    check("abort_font_addr", 32'(font_addr), 32'h0);
    check("abort_cursor_col", 32'(cursor_col), 32'd0);
    check("abort_cursor_row", 32'(cursor_row), 32'd0);
    @(posedge pixel_clk);
    #1;
    rst_n = 1'b1;
    // Write held across the whole clear must land on the first idle cycle
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    count_busy(n, rdy_hi);
    check("abort_clear_cycles", 32'(n), 32'd2400);
    check("abort_clear_ready_low", 32'(rdy_hi), 32'd0);
    @(posedge pixel_clk);
    #1;
    wr_valid = 1'b0;
    check("held_cursor_col", 32'(cursor_col), 32'd1);
    check("held_cursor_row", 32'(cursor_row), 32'd0);
    model_blank();
    model[0][0] = 8'h55;
    scan_rows(0, 0);
    scan_rows(29, 29);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
